// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encodings and bus width default.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } sw_state_t;

    localparam int BCD_W_DEFAULT = 24;

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low push button: 2-FF synchronizer, stable-level filter
// and a one-cycle press pulse on each accepted high-to-low change.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;
    logic [1:0]    warm;
    logic          armed;
    logic          accept;

    assign accept = (sync2 != level) && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // The count is the run length of consecutive samples disagreeing with the filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync2 == level) begin
            count <= '0;
        end else if (count == LAST) begin
            level <= sync2;
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Presses are only honoured once a genuine released level has been seen after reset,
    // so a key held down through reset stays silent until it is released and pressed again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm  <= 2'b00;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && sync2 && level) begin
                armed <= 1'b1;
            end
            press <= accept && level && !sync2 && armed;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced start/stop and lap/clear keys drive the counter
// enable/clear, the lap capture register and the display mux/blanking.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BCD_W           = BCD_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             key_ss,
    input  logic             key_lap,
    input  logic [BCD_W-1:0] cnt_bcd,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             disp_blank,
    output logic [1:0]       state
);

    sw_state_t        cur;
    sw_state_t        nxt;
    logic             ss_press;
    logic             lap_press;
    logic             clr_next;
    logic             capture;
    logic             blank_next;
    logic [BCD_W-1:0] lap_reg;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
        .clk   (clk),
        .rst   (rst),
        .key   (key_ss),
        .press (ss_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk   (clk),
        .rst   (rst),
        .key   (key_lap),
        .press (lap_press)
    );

    // Start/stop wins over a coincident lap press, which is then simply dropped.
    always_comb begin
        nxt      = cur;
        clr_next = 1'b0;
        capture  = 1'b0;
        if (ss_press) begin
            case (cur)
                IDLE:  nxt = RUN;
                RUN:   nxt = PAUSE;
                PAUSE: nxt = RUN;
                LAP:   nxt = PAUSE;
            endcase
        end else if (lap_press) begin
            case (cur)
                IDLE:  clr_next = 1'b1;
                RUN: begin
                    nxt     = LAP;
                    capture = 1'b1;
                end
                LAP:   nxt = RUN;
                PAUSE: begin
                    nxt      = IDLE;
                    clr_next = 1'b1;
                end
            endcase
        end
        blank_next = ((cur == PAUSE) && (nxt == PAUSE)) ? (disp_blank ^ tick) : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            cnt_clr    <= 1'b0;
            disp_blank <= 1'b0;
            lap_reg    <= '0;
        end else begin
            cur        <= nxt;
            cnt_clr    <= clr_next;
            disp_blank <= blank_next;
            if (capture) begin
                lap_reg <= cnt_bcd;
            end
        end
    end

    assign cnt_en   = tick && ((cur == RUN) || (cur == LAP));
    assign disp_bcd = (cur == LAP) ? lap_reg : cnt_bcd;
    assign state    = cur;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable clk cycles required to accept a key level change (20 ms at 50 MHz).
REQ-002 Parameter BCD_W, default 24, is the width of the six-digit BCD count bus.
REQ-003 Port clk, input, 1, is the single system clock; all logic is rising-edge triggered.
REQ-004 Port rst, input, 1, is the asynchronous active-high reset.
REQ-005 Port tick, input, 1, is a one-cycle time-base enable pulse from the prescaler.
REQ-006 Port key_ss, input, 1, is the raw asynchronous active-low start/stop button.
REQ-007 Port key_lap, input, 1, is the raw asynchronous active-low lap/clear button.
REQ-008 Port cnt_bcd, input, BCD_W, is the live BCD count returned by the counter.
REQ-009 Port cnt_en, output, 1, is the counter advance strobe.
REQ-010 Port cnt_clr, output, 1, is the counter synchronous-clear pulse.
REQ-011 Port disp_bcd, output, BCD_W, is the value routed to the digit decoders.
REQ-012 Port disp_blank, output, 1, blanks all digits when high.
REQ-013 Port state, output, 2, exposes the FSM state for debug.

Function
REQ-014 Each key SHALL pass through a 2-FF synchronizer, then a debouncer that changes its filtered level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 A filtered high-to-low transition SHALL produce exactly one one-cycle press pulse, no later than DEBOUNCE_CYCLES+3 cycles after the raw key settles low; release produces no pulse.
REQ-016 FSM states SHALL be IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-017 IDLE: ss press -> RUN; lap press -> stay IDLE, cnt_clr pulse.
REQ-018 RUN: ss press -> PAUSE; lap press -> LAP, lap register captures cnt_bcd in that cycle.
REQ-019 LAP: lap press -> RUN; ss press -> PAUSE.
REQ-020 PAUSE: ss press -> RUN; lap press -> IDLE, cnt_clr pulse.
REQ-021 When ss and lap pulses coincide, ss SHALL take priority and the lap pulse SHALL be discarded.
REQ-022 cnt_en SHALL be combinational: tick AND current state in {RUN, LAP}; a tick in the same cycle as a transition uses the pre-transition state.
REQ-023 cnt_clr SHALL be a registered one-cycle pulse in the cycle after the qualifying lap press.
REQ-024 disp_bcd SHALL equal the lap register in LAP and cnt_bcd in all other states (combinational mux).
REQ-025 disp_blank SHALL be 0 on entry to PAUSE, toggle on every tick while in PAUSE, and be 0 in every other state.
REQ-026 The lap register SHALL hold its value until the next RUN->LAP capture or reset.

Reset
REQ-027 While rst is high: state=IDLE, cnt_clr=0, disp_blank=0, lap register=0, debouncer filtered levels=1 (released), debounce counters=0, synchronizers=1.
REQ-028 Reset asserted mid-operation SHALL abort any pending press pulse; no pulse is generated from a key already held low at reset release until it has been released and pressed again.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the state encodings and the BCD_W default.
REQ-030 Sub-module key_debounce (synchronizer, filter, press-pulse) SHALL be instantiated once per key.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Assert rst for 3 cycles with cnt_bcd=24'h000042 -> state=00, cnt_en=0, cnt_clr=0, disp_blank=0, disp_bcd=24'h000042.
REQ-032 Hold key_ss low 12 cycles, then apply 3 ticks -> state=01, exactly 3 cnt_en pulses.
REQ-033 In RUN with cnt_bcd=24'h000123, press lap, then drive cnt_bcd to 24'h000125 -> state=11, disp_bcd=24'h000123; press lap again -> state=01, disp_bcd=24'h000125.
REQ-034 In RUN press ss, apply 4 ticks -> state=10, no cnt_en, disp_blank sequence 1,0,1,0; press lap -> one cnt_clr pulse, state=00, disp_blank=0.
REQ-035 Toggle key_lap every 2 cycles for 20 cycles -> no press pulse; then hold low 12 cycles -> exactly one pulse.
REQ-036 In RUN force simultaneous ss and lap press pulses -> state=10, lap register unchanged; assert rst while in LAP -> state=00, lap register=0.
